// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial input, FIFO read port and error flags of the configurable UART receiver
interface uart_rx_cfg_if;
  logic       RX;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;
  logic       par_err;
  logic       ovr_err;
  modport master (
    output RX, rd_en, clr_err,
    input  rx_data, rx_rdy, frm_err, par_err, ovr_err
  );
  modport slave (
    input  RX, rd_en, clr_err,
    output rx_data, rx_rdy, frm_err, par_err, ovr_err
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable framing, glitch rejection, sticky errors and a FWFT FIFO
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_cfg_if.slave bus
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par_bad, par_bad_n;
  logic                 tick, push, pop, full, rdy;
  logic                 frm_set, par_set, ovr_set;
  logic                 frm_err, par_err, ovr_err;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [AW:0]          used;
  assign tick = cnt == '0;
  assign rdy  = used != '0;
  assign full = used == (AW+1)'(FIFO_DEPTH);
  assign pop  = bus.rd_en && rdy;
  assign bus.rx_rdy  = rdy;
  assign bus.rx_data = rdy ? mem[rp] : 8'h00;
  assign bus.frm_err = frm_err;
  assign bus.par_err = par_err;
  assign bus.ovr_err = ovr_err;
  // two-flop synchroniser, reset high so reset release never looks like a start edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s, rx_m} <= 2'b11;
    else {rx_s, rx_m} <= {rx_m, bus.RX};
  // frame state register: state, baud countdown, bit index, shift register, parity verdict
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sh      <= sh_n;
      par_bad <= par_bad_n;
    end
  // next-state and frame outcome; every sample happens when the countdown hits zero
  always_comb begin
    state_n   = state;
    cnt_n     = tick ? cnt : cnt - 1'b1;
    idx_n     = idx;
    sh_n      = sh;
    par_bad_n = par_bad;
    push      = 1'b0;
    frm_set   = 1'b0;
    par_set   = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = CW'(H - 1);
        state_n = rx_s ? IDLE : START;
      end
      START: if (tick) begin
        state_n   = rx_s ? IDLE : DATA;
        cnt_n     = CW'(CLKS_PER_BIT - 1);
        idx_n     = '0;
        par_bad_n = 1'b0;
      end
      DATA: if (tick) begin
        sh_n    = {rx_s, sh[DATA_BITS-1:1]};
        cnt_n   = CW'(CLKS_PER_BIT - 1);
        idx_n   = idx + 1'b1;
        state_n = idx != 3'(DATA_BITS - 1) ? DATA : PARITY != 0 ? PAR : STOP;
      end
      PAR: if (tick) begin
        par_bad_n = ^{sh, rx_s, PARITY == 1};
        cnt_n     = CW'(CLKS_PER_BIT - 1);
        state_n   = STOP;
      end
      STOP: if (tick) begin
        state_n = IDLE;
        frm_set = !rx_s;
        par_set = rx_s && par_bad;
        ovr_set = rx_s && full && !pop;
        push    = rx_s && !(full && !pop);
      end
      default: state_n = IDLE;
    endcase
  end
  // FIFO storage, zero-extended so bits above the data width read as 0
  always_ff @(posedge clk)
    if (push) mem[wp] <= 8'(sh);
  // FIFO pointers and occupancy; push and pop may coincide at any fill level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp   <= '0;
      rp   <= '0;
      used <= '0;
    end else begin
      wp   <= wp + AW'(push);
      rp   <= rp + AW'(pop);
      used <= used + (AW+1)'(push) - (AW+1)'(pop);
    end
  // sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {frm_err, par_err, ovr_err} <= 3'b000;
    else begin
      frm_err <= frm_set | (frm_err & ~bus.clr_err);
      par_err <= par_set | (par_err & ~bus.clr_err);
      ovr_err <= ovr_set | (ovr_err & ~bus.clr_err);
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized bench checking three receiver configurations against a frame-level model
module tb_uart_rx_cfg;
  localparam int C = 16;
  localparam int H = C / 2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin [3];
  logic       rd [3];
  logic       clr [3];
  logic [7:0] dout [3];
  logic       rdy [3];
  logic       fe [3];
  logic       pe [3];
  logic       oe [3];
  int         nbits [3] = '{8, 8, 5};
  int         pmode [3] = '{0, 2, 1};
  int         depth [3] = '{4, 4, 2};
  logic [7:0] mq [3][$];
  bit         mf [3];
  bit         mp [3];
  bit         mo [3];
  int         n_chk = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_u
    uart_rx_cfg_if bus ();
    assign bus.RX      = rx_pin[g];
    assign bus.rd_en   = rd[g];
    assign bus.clr_err = clr[g];
    assign dout[g]     = bus.rx_data;
    assign rdy[g]      = bus.rx_rdy;
    assign fe[g]       = bus.frm_err;
    assign pe[g]       = bus.par_err;
    assign oe[g]       = bus.ovr_err;
    uart_rx_cfg #(
      .CLKS_PER_BIT(C),
      .DATA_BITS(g == 2 ? 5 : 8),
      .PARITY(g == 0 ? 0 : g == 1 ? 2 : 1),
      .FIFO_DEPTH(g == 2 ? 2 : 4)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_state(input int u, input string tag);
    bit ne = mq[u].size() != 0;
    chk($sformatf("%s u%0d rx_rdy", tag, u), 32'(rdy[u]), 32'(ne));
    chk($sformatf("%s u%0d rx_data", tag, u), 32'(dout[u]), ne ? 32'(mq[u][0]) : 32'h0);
    chk($sformatf("%s u%0d frm_err", tag, u), 32'(fe[u]), 32'(mf[u]));
    chk($sformatf("%s u%0d par_err", tag, u), 32'(pe[u]), 32'(mp[u]));
    chk($sformatf("%s u%0d ovr_err", tag, u), 32'(oe[u]), 32'(mo[u]));
  endtask
  task automatic send(input int u, input logic [7:0] d, input bit par_ok = 1, input bit stop = 1,
                      input bit pop_s = 0);
    logic [7:0] dm = d & 8'((1 << nbits[u]) - 1);
    logic       pbit = (^dm) ^ (pmode[u] == 1) ^ !par_ok;
    bit         full;
    bit         popped;
    rx_pin[u] = 1'b0;
    cyc(C);
    for (int k = 0; k < nbits[u]; k++) begin
      rx_pin[u] = dm[k];
      cyc(C);
    end
    if (pmode[u] != 0) begin
      rx_pin[u] = pbit;
      cyc(C);
    end
    rx_pin[u] = stop;
    cyc(H + 2);
    check_state(u, "pre_stop");
    rd[u] = pop_s;
    cyc(1);
    rd[u] = 1'b0;
    full   = mq[u].size() == depth[u];
    popped = pop_s && mq[u].size() != 0;
    if (popped) void'(mq[u].pop_front());
    if (!stop) mf[u] = 1'b1;
    else begin
      if (pmode[u] != 0 && !par_ok) mp[u] = 1'b1;
      if (full && !popped) mo[u] = 1'b1;
      else mq[u].push_back(dm);
    end
    check_state(u, "post_stop");
    rx_pin[u] = 1'b1;
    cyc(C - H - 3 + (stop ? 0 : 2 * C));
  endtask
  task automatic pop(input int u);
    rd[u] = 1'b1;
    cyc(1);
    rd[u] = 1'b0;
    if (mq[u].size() != 0) void'(mq[u].pop_front());
    check_state(u, "pop");
  endtask
  task automatic clear(input int u);
    clr[u] = 1'b1;
    cyc(1);
    clr[u] = 1'b0;
    mf[u] = 1'b0;
    mp[u] = 1'b0;
    mo[u] = 1'b0;
    check_state(u, "clr");
  endtask
  task automatic glitch(input int u);
    rx_pin[u] = 1'b0;
    cyc(4);
    rx_pin[u] = 1'b1;
    cyc(2 * C);
    check_state(u, "glitch");
  endtask
  task automatic abort(input int u);
    rx_pin[u] = 1'b0;
    cyc(C);
    rx_pin[u] = 1'b1;
    cyc(2 * C);
    rst_n = 1'b0;
    cyc(2);
    for (int v = 0; v < 3; v++) begin
      mq[v].delete();
      mf[v] = 1'b0;
      mp[v] = 1'b0;
      mo[v] = 1'b0;
    end
    check_state(u, "in_reset");
    rst_n = 1'b1;
    cyc(C);
    for (int v = 0; v < 3; v++) check_state(v, "after_reset");
  endtask
  initial begin
    for (int v = 0; v < 3; v++) begin
      rx_pin[v] = 1'b1;
      rd[v]     = 1'b0;
      clr[v]    = 1'b0;
    end
    cyc(3);
    for (int v = 0; v < 3; v++) check_state(v, "reset");
    rst_n = 1'b1;
    cyc(2 * C);
    send(0, 8'hA5);
    pop(0);
    glitch(0);
    send(0, 8'h3C);
    pop(0);
    for (int d = 1; d <= 5; d++) send(0, 8'(d));
    repeat (5) pop(0);
    clear(0);
    for (int d = 1; d <= 4; d++) send(0, 8'(d));
    send(0, 8'h05, 1, 1, 1);
    repeat (5) pop(0);
    send(1, 8'h07, 0);
    send(1, 8'h55, 1, 0);
    clear(1);
    pop(1);
    send(2, 8'h1F);
    abort(2);
    send(2, 8'h0A);
    pop(2);
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 25; i++) begin
        int r = $urandom_range(0, 15);
        send(v, 8'($urandom), r != 0, r != 1, $urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 2)) pop(v);
        if ($urandom_range(0, 5) == 0) clear(v);
      end
      repeat (depth[v] + 1) pop(v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
